// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bram_port_arbiter
// Purpose : Shares one block-RAM port between two requesters with a
//           req/gnt/rvalid handshake. Round-robin or fixed-priority
//           arbitration. Sequences the RAM's registered one-cycle read
//           latency and routes read (or write-through) data back to the
//           requester that owns the access.
// Revision: 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  // Winner of the most recent arbitration; it also owns the access in
  // flight, so it steers rvalid during RESP.
  logic                  r_last_winner;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic                  r_busy;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_any_req;
  logic                  w_pick1;

  // Arbitration decision: a lone requester wins; on a tie either
  // requester 0 wins outright or the one that did not win last time.
  always_comb begin
    w_any_req = req0 | req1;
    if (req0 && req1) begin
      w_pick1 = (FIXED_PRIORITY != 0) ? 1'b0 : ~r_last_winner;
    end else begin
      w_pick1 = req1;
    end
  end

  // Control FSM, RAM port drive and response strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_winner <= 1'b1;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_rvalid0     <= 1'b0;
      r_rvalid1     <= 1'b0;
      r_busy        <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data    <= '0;
      r_rdata       <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;

      // The RAM output is only meaningful in RESP; capture it so rdata
      // keeps the last returned word once rvalid drops.
      if (r_state == S_RESP) begin
        r_rdata <= mem_q;
      end

      case (r_state)
        S_ACCESS: begin
          // RAM samples the port at this edge; its output is ready in RESP.
          r_state   <= S_RESP;
          r_mem_we  <= 1'b0;
          r_busy    <= 1'b1;
          r_rvalid0 <= ~r_last_winner;
          r_rvalid1 <= r_last_winner;
        end
        default: begin
          // IDLE and RESP both arbitrate, giving back-to-back accesses.
          if (w_any_req) begin
            r_state       <= S_ACCESS;
            r_last_winner <= w_pick1;
            r_gnt0        <= ~w_pick1;
            r_gnt1        <= w_pick1;
            r_busy        <= 1'b1;
            r_mem_addr    <= w_pick1 ? addr1  : addr0;
            r_mem_data    <= w_pick1 ? wdata1 : wdata0;
            r_mem_we      <= w_pick1 ? we1    : we0;
          end else begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_mem_we <= 1'b0;
          end
        end
      endcase
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;
  assign busy     = r_busy;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  // During RESP the RAM's registered output is the response itself;
  // otherwise present the held copy.
  assign rdata    = (r_rvalid0 | r_rvalid1) ? mem_q : r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bram_port_arbiter
// Purpose : Drives two arbiters (round-robin and fixed-priority) with the
//           same directed stimulus, each on its own RAM, and checks them
//           against a transaction-level reference schedule every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NI = 2;
  localparam int NC = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          ram_load;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          gnt0[NI], gnt1[NI], rvalid0[NI], rvalid1[NI], busy[NI], mem_we[NI];
  logic [DW-1:0] rdata[NI], mem_data[NI], mem_q[NI];
  logic [AW-1:0] mem_addr[NI];

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIORITY(0)) u_rr (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]),
    .rdata(rdata[0]), .busy(busy[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]),
    .mem_we(mem_we[0]), .mem_q(mem_q[0]));

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIORITY(1)) u_fp (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]),
    .rdata(rdata[1]), .busy(busy[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]),
    .mem_we(mem_we[1]), .mem_q(mem_q[1]));

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    if (a == 10'h005) return 16'h1234;
    return {lo ^ 8'hA5, lo};
  endfunction

  // Write-through RAM with registered output, one per arbiter.
  logic [DW-1:0] ram[NI][1<<AW];
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (ram_load) begin
        for (int a = 0; a < (1 << AW); a++) ram[i][a] <= init_word(AW'(a));
        mem_q[i] <= '0;
      end else if (mem_we[i]) begin
        ram[i][mem_addr[i]] <= mem_data[i];
        mem_q[i]            <= mem_data[i];
      end else begin
        mem_q[i] <= ram[i][mem_addr[i]];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s t=%0t got=%0h want=%0h", inst, nm, $time, act, exp);
    end
  endtask

  // Reference schedule: per cycle index, what each arbiter must show.
  int            cyc;
  logic [1:0]    e_gnt[NI][NC];   // 0 none, 1 requester0, 2 requester1
  logic [1:0]    e_rv[NI][NC];
  logic          e_busy[NI][NC], e_we[NI][NC], e_rst[NI][NC];
  logic [AW-1:0] e_addr[NI][NC];
  logic [DW-1:0] e_wd[NI][NC], e_dat[NI][NC];

  initial begin : model
    logic [DW-1:0] ref_mem[NI][1<<AW];
    int            nxt[NI];
    int            last[NI];
    int            e, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          wr;
    cyc = 0;
    for (int i = 0; i < NI; i++) begin
      nxt[i] = 0;
      last[i] = 1;
      for (int c = 0; c < NC; c++) begin
        e_gnt[i][c] = 0; e_rv[i][c] = 0; e_busy[i][c] = 0; e_we[i][c] = 0;
        e_rst[i][c] = 0; e_addr[i][c] = 0; e_wd[i][c] = 0; e_dat[i][c] = 0;
      end
      for (int k = 0; k < (1 << AW); k++) ref_mem[i][k] = init_word(AW'(k));
    end
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      e = cyc;
      if (e + 1 < NC) begin
        for (int i = 0; i < NI; i++) begin
          if (reset) begin
            e_gnt[i][e] = 0; e_rv[i][e] = 0; e_busy[i][e] = 0;
            e_gnt[i][e+1] = 0; e_rv[i][e+1] = 0; e_busy[i][e+1] = 0;
            e_rst[i][e] = 1;
            last[i] = 1;
            nxt[i] = e + 1;
          end else if (e >= nxt[i] && (req0 || req1)) begin
            if (req0 && req1) w = (i == 1) ? 0 : 1 - last[i];
            else w = req0 ? 0 : 1;
            a  = w ? addr1 : addr0;
            d  = w ? wdata1 : wdata0;
            wr = w ? we1 : we0;
            e_gnt[i][e]  = 2'(w + 1);
            e_addr[i][e] = a;
            e_wd[i][e]   = d;
            e_we[i][e]   = wr;
            e_busy[i][e] = 1;
            e_busy[i][e+1] = 1;
            if (wr) ref_mem[i][a] = d;
            e_rv[i][e+1]  = 2'(w + 1);
            e_dat[i][e+1] = ref_mem[i][a];
            last[i] = w;
            nxt[i]  = e + 2;
          end
        end
      end
    end
  end

  int gq_who[NI][$];
  int gq_cyc[NI][$];

  // Every-cycle comparison against the schedule, plus a log of grants.
  initial begin : compare
    logic [DW-1:0] hold[NI];
    forever begin
      @(negedge clk);
      if (cyc > 0 && cyc < NC) begin
        for (int i = 0; i < NI; i++) begin
          if (e_rst[i][cyc]) hold[i] = '0;
          if (e_rv[i][cyc] != 0) hold[i] = e_dat[i][cyc];
          chk(i, "gnt0", gnt0[i], e_gnt[i][cyc] == 1);
          chk(i, "gnt1", gnt1[i], e_gnt[i][cyc] == 2);
          chk(i, "rvalid0", rvalid0[i], e_rv[i][cyc] == 1);
          chk(i, "rvalid1", rvalid1[i], e_rv[i][cyc] == 2);
          chk(i, "busy", busy[i], e_busy[i][cyc]);
          chk(i, "mem_we", mem_we[i], (e_gnt[i][cyc] != 0) ? e_we[i][cyc] : 1'b0);
          chk(i, "rdata", rdata[i], hold[i]);
          if (e_gnt[i][cyc] != 0) begin
            chk(i, "mem_addr", mem_addr[i], e_addr[i][cyc]);
            chk(i, "mem_data", mem_data[i], e_wd[i][cyc]);
          end
          if (gnt0[i]) begin gq_who[i].push_back(0); gq_cyc[i].push_back(cyc); end
          if (gnt1[i]) begin gq_who[i].push_back(1); gq_cyc[i].push_back(cyc); end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt0(output int at);
    int n = 0;
    while (!gnt0[0] && n < 8) begin tick(); n++; end
    chk(0, "gnt0_seen", gnt0[0], 1);
    at = cyc;
  endtask

  task automatic wait_rv0();
    int n = 0;
    while (!rvalid0[0] && n < 8) begin tick(); n++; end
    chk(0, "rvalid0_seen", rvalid0[0], 1);
  endtask

  initial begin : stimulus
    int exp_rr[5];
    int exp_fp[5];
    int at, prev;
    exp_rr = '{0, 1, 0, 1, 1};
    exp_fp = '{0, 0, 0, 0, 1};
    reset = 1'b1; ram_load = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tick(); tick();
    reset = 1'b0; ram_load = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk(i, "rst_mem_addr", mem_addr[i], 0);
      chk(i, "rst_busy", busy[i], 0);
      chk(i, "rst_rdata", rdata[i], 0);
      chk(i, "rst_mem_we", mem_we[i], 0);
    end
    tick();

    // Single read of address 5.
    req0 = 1; we0 = 0; addr0 = 10'h005;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk(i, "rd5_gnt0", gnt0[i], 1);
      chk(i, "rd5_mem_addr", mem_addr[i], 10'h005);
      chk(i, "rd5_mem_we", mem_we[i], 0);
    end
    req0 = 0;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk(i, "rd5_rvalid0", rvalid0[i], 1);
      chk(i, "rd5_rdata", rdata[i], 16'h1234);
    end
    tick();
    for (int i = 0; i < NI; i++) chk(i, "rd5_busy_after", busy[i], 0);

    // Write BEEF to 3FF, then read it back back-to-back.
    req1 = 1; we1 = 1; addr1 = 10'h3FF; wdata1 = 16'hBEEF;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk(i, "wr_gnt1", gnt1[i], 1);
      chk(i, "wr_mem_we", mem_we[i], 1);
      chk(i, "wr_mem_addr", mem_addr[i], 10'h3FF);
    end
    req1 = 0; we1 = 0;
    req0 = 1; we0 = 0; addr0 = 10'h3FF;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk(i, "wr_mem_we_drop", mem_we[i], 0);
      chk(i, "wr_rvalid1", rvalid1[i], 1);
      chk(i, "wr_rdata", rdata[i], 16'hBEEF);
    end
    tick();
    for (int i = 0; i < NI; i++) chk(i, "rb_gnt0", gnt0[i], 1);
    req0 = 0;
    tick();
    for (int i = 0; i < NI; i++) chk(i, "rb_rdata", rdata[i], 16'hBEEF);
    tick();

    // Requester 1 read, so requester 0 is next in round-robin order.
    req1 = 1; we1 = 0; addr1 = 10'h022;
    tick();
    req1 = 0;
    tick();
    for (int i = 0; i < NI; i++) chk(i, "rd22_rdata", rdata[i], init_word(10'h022));
    tick();

    // Continuous tie, then requester 0 drops out.
    for (int i = 0; i < NI; i++) begin gq_who[i].delete(); gq_cyc[i].delete(); end
    req0 = 1; we0 = 0; addr0 = 10'h011;
    req1 = 1; we1 = 0; addr1 = 10'h022;
    repeat (8) tick();
    req0 = 0;
    tick();
    req1 = 0;
    tick(); tick(); tick();
    for (int i = 0; i < NI; i++) begin
      chk(i, "tie_count", gq_who[i].size(), 5);
      for (int k = 0; k < 5 && k < gq_who[i].size(); k++)
        chk(i, "tie_order", gq_who[i][k], (i == 0) ? exp_rr[k] : exp_fp[k]);
      for (int k = 1; k < 4 && k < gq_cyc[i].size(); k++)
        chk(i, "tie_spacing", gq_cyc[i][k] - gq_cyc[i][k-1], 2);
    end

    // Reset while a write to address 7 is in its access cycle.
    req0 = 1; we0 = 1; addr0 = 10'h007; wdata0 = 16'hCAFE;
    tick();
    for (int i = 0; i < NI; i++) chk(i, "abort_mem_we_pre", mem_we[i], 1);
    reset = 1; req0 = 0; we0 = 0;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk(i, "abort_mem_we", mem_we[i], 0);
      chk(i, "abort_busy", busy[i], 0);
    end
    reset = 0;
    tick();
    for (int i = 0; i < NI; i++) chk(i, "abort_no_rvalid", rvalid0[i] | rvalid1[i], 0);
    req0 = 1; addr0 = 10'h030; req1 = 1; addr1 = 10'h040;
    tick();
    for (int i = 0; i < NI; i++) chk(i, "post_rst_tie_gnt0", gnt0[i], 1);
    req0 = 0; req1 = 0;
    tick(); tick();

    // One requester streaming addresses 1, 2, 3.
    req0 = 1; we0 = 0; addr0 = 10'h001;
    prev = 0;
    for (int k = 1; k <= 3; k++) begin
      wait_gnt0(at);
      if (k > 1) chk(0, "stream_spacing", at - prev, 2);
      prev = at;
      addr0 = AW'(k + 1);
      if (k == 3) req0 = 0;
      wait_rv0();
      chk(0, "stream_rdata", rdata[0], init_word(AW'(k)));
    end
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
